// File: rtl/dds_phase_pkg.sv
// rtl/dds_phase_pkg.sv - shared types and constants for the DDS phase accumulator/MAC.
package dds_phase_pkg;

  localparam int DDS_LAT     = 4;
  localparam int DDS_PHASE_W = 48;
  localparam int DDS_POFF_W  = 14;

  typedef enum logic [1:0] {
    OP_EVAL   = 2'd0,
    OP_LOAD   = 2'd1,
    OP_RETUNE = 2'd2,
    OP_RSVD   = 2'd3
  } dds_op_e;

  typedef struct packed {
    logic [DDS_PHASE_W-1:0] freq;
    logic [DDS_PHASE_W-1:0] toff;
    logic [DDS_PHASE_W-1:0] acc;
    logic [DDS_POFF_W-1:0]  poff;
  } dds_profile_t;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dds_phase_mac_if.sv
// rtl/dds_phase_mac_if.sv - command/result bundle between the sequencer and the DDS phase MAC.
interface dds_phase_mac_if
  import dds_phase_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int PHASE_W = 48,
  parameter int POFF_W  = 14
);
  localparam int CH_W = ch_width(NUM_CH);

  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_op;
  logic [CH_W-1:0]    in_ch;
  logic [PHASE_W-1:0] in_ts;
  logic [PHASE_W-1:0] in_freq;
  logic [PHASE_W-1:0] in_toff;
  logic [POFF_W-1:0]  in_poff;
  logic [PHASE_W-1:0] in_acc;
  logic               out_valid;
  logic [CH_W-1:0]    out_ch;
  logic [PHASE_W-1:0] out_phase;
  logic               err_op;

  modport master (
    output in_valid, in_op, in_ch, in_ts, in_freq, in_toff, in_poff, in_acc,
    input  in_ready, out_valid, out_ch, out_phase, err_op
  );

  modport slave (
    input  in_valid, in_op, in_ch, in_ts, in_freq, in_toff, in_poff, in_acc,
    output in_ready, out_valid, out_ch, out_phase, err_op
  );

endinterface

// File: rtl/dds_phase_mul.sv
// rtl/dds_phase_mul.sv - 2-stage W x W unsigned multiplier truncated to W bits, built from 16-bit slices.
module dds_phase_mul #(
  parameter int W = 48
) (
  input  logic         clk,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] p
);

  localparam int NSL = (W + 15) / 16;
  localparam int PW  = NSL * 16;

  logic [PW-1:0] a_pad;
  logic [PW-1:0] b_pad;
  logic [31:0]   pp_q [NSL][NSL];
  logic [PW-1:0] sum;
  logic [W-1:0]  p_q;

  assign a_pad = PW'(a);
  assign b_pad = PW'(b);

  // Slice pairs whose weight lands at or above 2^PW never reach the truncated result.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NSL; i++) begin
      for (int j = 0; j < NSL; j++) begin
        if (i + j < NSL) begin
          pp_q[i][j] <= 32'(a_pad[16*i +: 16]) * 32'(b_pad[16*j +: 16]);
        end else begin
          pp_q[i][j] <= '0;
        end
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < NSL; i++) begin
      for (int j = 0; j < NSL; j++) begin
        if (i + j < NSL) begin
          sum = sum + (PW'(pp_q[i][j]) << (16 * (i + j)));
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    p_q <= sum[W-1:0];
  end

  assign p = p_q;

endmodule

// File: rtl/dds_phase_mac.sv
// rtl/dds_phase_mac.sv - multi-channel DDS phase MAC with per-channel profiles.
// Phase-continuous RETUNE is built only when DDS_RETUNE_EN is defined.
module dds_phase_mac
  import dds_phase_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int PHASE_W = 48,
  parameter int POFF_W  = 14
) (
  input  logic           clk,
  input  logic           resetn,
  dds_phase_mac_if.slave bus
);

  localparam int CH_W = ch_width(NUM_CH);
  localparam int SH   = PHASE_W - POFF_W;

  logic [PHASE_W-1:0] prof_freq [NUM_CH];
  logic [PHASE_W-1:0] prof_toff [NUM_CH];
  logic [PHASE_W-1:0] prof_acc  [NUM_CH];
  logic [POFF_W-1:0]  prof_poff [NUM_CH];

  dds_op_e         op;
  logic            accept;
  logic            ch_ok;
  logic [CH_W-1:0] rd_ch;
  logic            go_eval;
  logic            go_load;
  logic            go_ret;
  logic            go_drop;

  logic [3:0]         pv;
  logic [CH_W-1:0]    pch   [4];
  logic [PHASE_W-1:0] pacc  [3];
  logic [POFF_W-1:0]  ppoff [3];
  logic [PHASE_W-1:0] s0_diff;
  logic [PHASE_W-1:0] s0_freq;
  logic [PHASE_W-1:0] prod;
  logic [PHASE_W-1:0] s3_phase;

  logic               out_valid_q;
  logic [CH_W-1:0]    out_ch_q;
  logic [PHASE_W-1:0] out_phase_q;
  logic               err_q;

  assign op     = dds_op_e'(bus.in_op);
  assign accept = bus.in_valid & bus.in_ready;
  assign ch_ok  = ({1'b0, bus.in_ch} < (CH_W + 1)'(NUM_CH));
  assign rd_ch  = ch_ok ? bus.in_ch : '0;

  always_comb begin
    go_eval = accept & ch_ok & (op == OP_EVAL);
    go_load = accept & ch_ok & (op == OP_LOAD);
`ifdef DDS_RETUNE_EN
    go_ret  = accept & ch_ok & (op == OP_RETUNE);
`else
    go_ret  = 1'b0;
`endif
    go_drop = accept & ~(go_eval | go_load | go_ret);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pv <= '0;
    end else begin
      pv <= {pv[2:0], go_eval | go_ret};
    end
  end

  // Datapath registers carry no reset; pv qualifies everything downstream.
  always_ff @(posedge clk) begin
    pch[0]   <= rd_ch;
    pch[1]   <= pch[0];
    pch[2]   <= pch[1];
    pch[3]   <= pch[2];
    s0_diff  <= bus.in_ts - prof_toff[rd_ch];
    s0_freq  <= prof_freq[rd_ch];
    pacc[0]  <= prof_acc[rd_ch];
    pacc[1]  <= pacc[0];
    pacc[2]  <= pacc[1];
    ppoff[0] <= prof_poff[rd_ch];
    ppoff[1] <= ppoff[0];
    ppoff[2] <= ppoff[1];
    s3_phase <= pacc[2] + prod + (PHASE_W'(ppoff[2]) << SH);
  end

  dds_phase_mul #(
    .W (PHASE_W)
  ) u_mul (
    .clk (clk),
    .a   (s0_diff),
    .b   (s0_freq),
    .p   (prod)
  );

`ifdef DDS_RETUNE_EN
  logic [3:0]         rv;
  logic [PHASE_W-1:0] rts   [4];
  logic [PHASE_W-1:0] rfreq [4];
  logic [POFF_W-1:0]  rpoff [4];
  logic [2:0]         stall_cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rv        <= '0;
      stall_cnt <= '0;
    end else begin
      rv <= {rv[2:0], go_ret};
      if (go_ret) begin
        stall_cnt <= 3'(DDS_LAT);
      end else if (stall_cnt != '0) begin
        stall_cnt <= stall_cnt - 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    rts[0]   <= bus.in_ts;
    rfreq[0] <= bus.in_freq;
    rpoff[0] <= bus.in_poff;
    for (int i = 1; i < 4; i++) begin
      rts[i]   <= rts[i-1];
      rfreq[i] <= rfreq[i-1];
      rpoff[i] <= rpoff[i-1];
    end
  end

  // Holding off new commands until write-back lets them see the retuned profile.
  assign bus.in_ready = (stall_cnt == '0);
`else
  assign bus.in_ready = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        prof_freq[i] <= '0;
        prof_toff[i] <= '0;
        prof_acc[i]  <= '0;
        prof_poff[i] <= '0;
      end
    end else begin
      if (go_load) begin
        prof_freq[bus.in_ch] <= bus.in_freq;
        prof_toff[bus.in_ch] <= bus.in_toff;
        prof_acc[bus.in_ch]  <= bus.in_acc;
        prof_poff[bus.in_ch] <= bus.in_poff;
      end
`ifdef DDS_RETUNE_EN
      // New offset is pre-subtracted from acc so the phase at in_ts is unchanged.
      if (rv[3]) begin
        prof_acc[pch[3]]  <= s3_phase - (PHASE_W'(rpoff[3]) << SH);
        prof_toff[pch[3]] <= rts[3];
        prof_freq[pch[3]] <= rfreq[3];
        prof_poff[pch[3]] <= rpoff[3];
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_phase_q <= '0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= pv[3];
      if (pv[3]) begin
        out_ch_q    <= pch[3];
        out_phase_q <= s3_phase;
      end
      if (go_drop) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_phase = out_phase_q;
  assign bus.err_op    = err_q;

endmodule

// File: tb/tb_dds_phase_mac.sv
// tb/tb_dds_phase_mac.sv - self-checking bench for dds_phase_mac; follows DDS_RETUNE_EN like the RTL.
module tb_dds_phase_mac;
  import dds_phase_pkg::*;

  localparam int PW  = 48;
  localparam int PO  = 14;
  localparam int SH  = PW - PO;
  localparam int NCH = 4;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  dds_phase_mac_if bus ();

  dds_phase_mac u_dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    int          due;
    logic [1:0]  ch;
    logic [PW-1:0] ph;
  } exp_t;

  exp_t         q[$];
  dds_profile_t m_prof [NCH];
  bit           m_err;
  int           ready_until;
  int           cyc = 0;
  int           compared = 0;
  int           mismatched = 0;
  logic [PW-1:0] last_exp;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Phase from the formula: acc + (ts - toff) * freq + poff aligned to the MSBs, all mod 2^48.
  function automatic logic [PW-1:0] phase_at(input logic [1:0] ch, input logic [PW-1:0] ts);
    logic [PW-1:0] d;
    logic [PW-1:0] p;
    logic [PW-1:0] po;
    d  = ts - m_prof[ch].toff;
    p  = d * m_prof[ch].freq;
    po = {m_prof[ch].poff, {SH{1'b0}}};
    return p + m_prof[ch].acc + po;
  endfunction

  function automatic void model_reset();
    q.delete();
    for (int i = 0; i < NCH; i++) m_prof[i] = '0;
    m_err       = 1'b0;
    ready_until = 0;
  endfunction

  // Called at the negedge before the accepting edge; results appear 4 edges after that edge.
  function automatic void model_accept(input logic [1:0] op, input logic [1:0] ch,
                                       input logic [PW-1:0] ts, input logic [PW-1:0] freq,
                                       input logic [PW-1:0] toff, input logic [PO-1:0] poff,
                                       input logic [PW-1:0] acc);
    exp_t e;
    case (op)
      2'd0: begin
        last_exp = phase_at(ch, ts);
        e = '{cyc + 5, ch, last_exp};
        q.push_back(e);
      end
      2'd1: begin
        m_prof[ch].freq = freq;
        m_prof[ch].toff = toff;
        m_prof[ch].acc  = acc;
        m_prof[ch].poff = poff;
      end
      2'd2: begin
`ifdef DDS_RETUNE_EN
        last_exp = phase_at(ch, ts);
        e = '{cyc + 5, ch, last_exp};
        q.push_back(e);
        m_prof[ch].acc  = last_exp - {poff, {SH{1'b0}}};
        m_prof[ch].toff = ts;
        m_prof[ch].freq = freq;
        m_prof[ch].poff = poff;
        ready_until     = cyc + 5;
`else
        m_err = 1'b1;
`endif
      end
      default: m_err = 1'b1;
    endcase
  endfunction

  task automatic set_in(input bit v, input logic [1:0] op, input logic [1:0] ch,
                        input logic [PW-1:0] ts, input logic [PW-1:0] freq,
                        input logic [PW-1:0] toff, input logic [PO-1:0] poff,
                        input logic [PW-1:0] acc);
    bus.in_valid = v;
    bus.in_op    = op;
    bus.in_ch    = ch;
    bus.in_ts    = ts;
    bus.in_freq  = freq;
    bus.in_toff  = toff;
    bus.in_poff  = poff;
    bus.in_acc   = acc;
  endtask

  task automatic send(input logic [1:0] op, input logic [1:0] ch,
                      input logic [PW-1:0] ts, input logic [PW-1:0] freq,
                      input logic [PW-1:0] toff, input logic [PO-1:0] poff,
                      input logic [PW-1:0] acc);
    bit done = 1'b0;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      set_in(1'b1, op, ch, ts, freq, toff, poff, acc);
      if (bus.in_ready) begin
        model_accept(op, ch, ts, freq, toff, poff, acc);
        done = 1'b1;
      end
    end
    if (!done) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout: in_ready stayed 0 for 20 cycles, required 1");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  function automatic logic [PW-1:0] rnd48();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    if ($urandom_range(0, 3) == 0) return PW'(t[11:0]);
    return t[PW-1:0];
  endfunction

  // Per-cycle compare of every output against the model.
  initial forever begin
    bit ev;
    @(posedge clk);
    #1;
    ev = (q.size() > 0) && (q[0].due == cyc);
    check("out_valid", 64'(bus.out_valid), 64'(ev));
    if (ev) begin
      check("out_ch", 64'(bus.out_ch), 64'(q[0].ch));
      check("out_phase", 64'(bus.out_phase), 64'(q[0].ph));
      q.delete(0);
    end
    check("in_ready", 64'(bus.in_ready), 64'(cyc >= ready_until));
    check("err_op", 64'(bus.err_op), 64'(m_err));
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within 400000 time units");
    $fatal(1);
  end

  initial begin
    logic [PW-1:0] r;
    model_reset();
    resetn = 1'b0;
    set_in(1'b0, 2'd0, 2'd0, '0, '0, '0, '0, '0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check("reset_out_phase", 64'(bus.out_phase), 64'd0);
    check("reset_out_ch", 64'(bus.out_ch), 64'd0);

    send(2'd1, 2'd0, '0, 48'h0001_0000_0000, 48'd100, 14'd0, '0);
    send(2'd0, 2'd0, 48'd101, '0, '0, 14'd0, '0);
    check("model_eval_ch0", 64'(last_exp), 64'h0001_0000_0000);
    send(2'd1, 2'd1, '0, 48'd1, 48'd1, 14'd0, '0);
    send(2'd0, 2'd1, 48'd0, '0, '0, 14'd0, '0);
    check("model_eval_wrap", 64'(last_exp), 64'hFFFF_FFFF_FFFF);
    send(2'd1, 2'd1, '0, 48'd0, 48'd1, 14'd1, '0);
    send(2'd0, 2'd1, 48'd0, '0, '0, 14'd0, '0);
    check("model_eval_poff", 64'(last_exp), 64'h0004_0000_0000);

`ifdef DDS_RETUNE_EN
    send(2'd2, 2'd0, 48'd200, 48'h0002_0000_0000, '0, 14'd0, '0);
    check("model_retune", 64'(last_exp), 64'h0064_0000_0000);
    send(2'd0, 2'd0, 48'd200, '0, '0, 14'd0, '0);
    check("model_after_retune", 64'(last_exp), 64'h0064_0000_0000);
    send(2'd0, 2'd0, 48'd201, '0, '0, 14'd0, '0);
    check("model_retune_step", 64'(last_exp), 64'h0066_0000_0000);
    send(2'd1, 2'd2, '0, 48'd5, 48'd0, 14'h1234, 48'd7);
    send(2'd2, 2'd2, 48'd10, 48'd9, '0, 14'h0abc, '0);
    r = last_exp;
    check("model_retune_poff", 64'(r), 64'h48D0_0000_0039);
    send(2'd0, 2'd2, 48'd10, '0, '0, 14'd0, '0);
    check("model_continuity", 64'(last_exp), 64'(r));
    send(2'd0, 2'd2, 48'd11, '0, '0, 14'd0, '0);
    check("model_new_freq", 64'(last_exp), 64'h48D0_0000_0042);
`else
    send(2'd2, 2'd0, 48'd200, 48'h0002_0000_0000, '0, 14'd0, '0);
    send(2'd0, 2'd0, 48'd201, '0, '0, 14'd0, '0);
    check("model_ch0_unchanged", 64'(last_exp), 64'h0065_0000_0000);
`endif

    for (int c = 0; c < NCH; c++) send(2'd0, 2'(c), 48'd300, '0, '0, 14'd0, '0);
    idle(6);
    send(2'd3, 2'd2, '0, '0, '0, 14'd0, '0);
    idle(6);

`ifdef DDS_RETUNE_EN
    send(2'd2, 2'd0, 48'd400, 48'd77, '0, 14'd5, '0);
`else
    send(2'd0, 2'd0, 48'd400, '0, '0, 14'd0, '0);
`endif
    idle(1);
    @(negedge clk);
    resetn = 1'b0;
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    send(2'd0, 2'd0, 48'd12345, '0, '0, 14'd0, '0);
    check("model_eval_after_reset", 64'(last_exp), 64'd0);
    idle(6);

    for (int i = 0; i < 400; i++) begin
      bit         v;
      logic [1:0] op;
      int         sel;
      logic [1:0] ch;
      logic [PW-1:0] ts, fr, to, ac;
      logic [PO-1:0] po;
      @(negedge clk);
      v   = ($urandom_range(0, 9) < 7);
      sel = $urandom_range(0, 19);
      op  = (sel < 10) ? 2'd0 : (sel < 15) ? 2'd1 : (sel < 19) ? 2'd2 : 2'd3;
      ch  = 2'($urandom_range(0, NCH - 1));
      ts  = rnd48();
      fr  = rnd48();
      to  = rnd48();
      ac  = rnd48();
      po  = PO'($urandom());
      set_in(v, op, ch, ts, fr, to, po, ac);
      if (v && bus.in_ready) model_accept(op, ch, ts, fr, to, po, ac);
    end
    idle(8);
    check("queue_drained", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dds_phase_mac.md
# dds_phase_mac

Multi-channel, parametrised phase accumulator/MAC for the DAC controller's DDS path. Per request it computes `phase = acc + ((ts − toff)·freq mod 2^PHASE_W) + (poff << (PHASE_W − POFF_W))` from per-channel profile registers. The block keeps the profiles internally. It supports profile load and phase-continuous retune, so a channel can change frequency at a timestamp without a phase jump. It sits between the timestamp/command sequencer and the per-channel sine LUTs.

## Interface
- `NUM_CH`, 4: number of channels; `CH_W = max(1, $clog2(NUM_CH))`.
- `PHASE_W`, 48: width of phase, frequency, timestamp and time offset.
- `POFF_W`, 14: width of the static phase offset; it is aligned to the phase MSBs.

- `clk`  in  1: clock.
- `resetn`  in  1: reset, synchronous, active-low.
- `in_valid`  in  1: command valid.
- `in_ready`  out  1: command ready. Accept = `in_valid & in_ready`.
- `in_op`  in  2: 0 EVAL, 1 LOAD, 2 RETUNE, 3 reserved.
- `in_ch`  in  CH_W: target channel.
- `in_ts`  in  PHASE_W: timestamp (EVAL/RETUNE).
- `in_freq`  in  PHASE_W: frequency word (LOAD/RETUNE).
- `in_toff`  in  PHASE_W: time offset (LOAD).
- `in_poff`  in  POFF_W: phase offset (LOAD/RETUNE).
- `in_acc`  in  PHASE_W: accumulated phase (LOAD).
- `out_valid`  out  1: result valid, single-cycle pulse per EVAL/RETUNE.
- `out_ch`  out  CH_W: channel of the result.
- `out_phase`  out  PHASE_W: computed phase.
- `err_op`  out  1: sticky; set on a dropped command; cleared only by reset.

## Operation
- Profiles per channel: `freq`, `toff`, `poff`, `acc`. All are zero after reset.
- The profile is read combinationally in the accept cycle. Later profile writes do not affect in-flight commands.
- EVAL: compute the phase with the current profile. Emit `out_valid`/`out_ch`/`out_phase`. The profile is unchanged.
- LOAD: write `freq`, `toff`, `poff` and `acc` at the accept edge. The new values are visible to a command accepted the next cycle. LOAD produces no output.
- RETUNE: compute the phase at `in_ts` with the *old* profile and emit it as for EVAL. In the same cycle as `out_valid`, write back `acc ← out_phase`, `toff ← in_ts`, `freq ← in_freq`, `poff ← 0`.
  - The new `in_poff` is held and folded in so that the phase stays continuous: `acc ← out_phase − (in_poff << (PHASE_W−POFF_W))` and `poff ← in_poff`.
- op 3, and `in_ch ≥ NUM_CH`: the command is accepted, dropped with no output and no write, and `err_op` is set.
- All arithmetic is unsigned modulo 2^PHASE_W: the subtraction wraps, the product is truncated to its low PHASE_W bits, and the sums wrap.

## Timing
- Latency: `out_valid` is asserted exactly 4 cycles after the accept edge (LAT = 4). The pipeline is fully pipelined, with one command per cycle.
- Pipeline stages:
  - S0: profile read and `ts − toff`.
  - S1/S2: 16-bit-sliced partial products and partial sums.
  - S3: final sum with `acc` and `poff`.
  - The output register follows S3.
- `in_ready` is 1 except during the 4 cycles after a RETUNE accept, when it is 0. It returns to 1 in the cycle after the write-back. This makes any following command see the retuned profile.
- There is no output back-pressure; downstream must accept every `out_valid`.
- Reset values: `in_ready` = 1, `out_valid` = 0, `out_ch` = 0, `out_phase` = 0, `err_op` = 0.
- Reset mid-operation: the pipeline is flushed, pending RETUNE write-backs are discarded and all profiles are cleared.
- A LOAD to the same channel in the cycle before an EVAL: the EVAL uses the new profile. LOAD and EVAL cannot be accepted in the same cycle (one command per cycle).

## Configuration
- `DDS_RETUNE_EN` defined: RETUNE behaves as described above, including the `in_ready` stall.
- Not defined: op 2 is treated like op 3 (dropped, `err_op` set). `in_ready` is constant 1 outside reset, and the write-back logic is absent.

## Structure
- Package `dds_phase_pkg`:
  - Op enum `dds_op_e` (EVAL, LOAD, RETUNE, RSVD).
  - `DDS_LAT = 4`.
  - Profile struct typedef, parametrised through package parameters for the default widths.
- Sub-module `dds_phase_mul`: a 2-stage pipelined PHASE_W×PHASE_W truncated unsigned multiplier built from 16-bit slices. It is instantiated once.

## Test plan
- LOAD ch0 `freq=2^32`, `toff=100`, `acc=0`, `poff=0`; EVAL `ts=101` → 4 cycles later `out_phase=0x0001_0000_0000`, `out_ch=0`.
- LOAD ch1 `freq=1`, `toff=1`; EVAL `ts=0` → `out_phase=0xFFFF_FFFF_FFFF` (wrap). LOAD ch1 `poff=1`, `freq=0` → EVAL gives `0x0004_0000_0000`.
- RETUNE ch0 at `ts=200` with `freq=2^33`:
  - Output `0x0064_0000_0000`, and `in_ready` is low for 4 cycles.
  - A following EVAL `ts=200` returns the same value.
  - EVAL `ts=201` returns `0x0066_0000_0000`.
- Back-to-back EVALs on channels 0..3 on consecutive cycles → four consecutive `out_valid` pulses with the correct `out_ch` order and values.
- op 3, then `in_ch=5` with `NUM_CH=5` unused → no output, `err_op=1`. Without `DDS_RETUNE_EN`, RETUNE also sets `err_op` and ch0 is unchanged.
- Accept RETUNE, assert `resetn=0` 2 cycles later → no `out_valid`, `in_ready=1` after reset, and EVAL on ch0 returns 0.
